ping_monitor: RTL and testbench
===============================

Name: ping_monitor

Overview:
- Sits directly downstream of the 32-bit wrap counter and consumes its `ping` output (all-ones count).
- Turns each new `ping` assertion into a single-cycle event and counts events in an epoch counter.
- Raises an acknowledged interrupt per event, and flags protocol faults: overrun, `ping` stuck high, optional missing-ping timeout.
- Target: SAT/equivalence-style checking alongside the counters.

Parameters:
- EPOCH_W, 16, width of event (epoch) counter
- STUCK_MAX, 4, consecutive high cycles of `ping` tolerated; STUCK_MAX >= 2
- TO_W, 33, width of timeout counter
- TIMEOUT, 33'h1_0000_0010, cycles without an event before timeout flag (only with PING_MON_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- ping  in  1  level from upstream counter
- irq_en  in  1  enables irq generation
- irq_ack  in  1  clears pending irq
- clr  in  1  clears sticky flags, epoch_cnt, timeout counter
- ping_evt  out  1  one-cycle event pulse
- epoch_cnt  out  EPOCH_W  events since reset/clr, wraps
- epoch_ovf  out  1  sticky: epoch_cnt wrapped
- irq  out  1  pending interrupt
- overrun  out  1  sticky: event while irq pending and not acked
- stuck  out  1  sticky: ping high > STUCK_MAX cycles
- timeout  out  1  sticky: no event within TIMEOUT cycles

Behaviour:
- Single clock domain; reset is synchronous, active-high, on `clk`/`rst`.
- Reset values: all outputs 0; FSM = DISARM; `high_cnt` = 0; `to_cnt` = 0. Reset mid-operation aborts everything, including a pending irq.
- FSM states DISARM, LOW, HIGH, STUCK:
  - DISARM: `ping`=0 -> LOW. `ping`=1 stays in DISARM with no event; a level already high at reset release never counts.
  - LOW: `ping`=1 -> HIGH and an event is detected.
  - HIGH: `ping`=0 -> LOW. `ping`=1 increments `high_cnt`; when `high_cnt` == STUCK_MAX-1 and `ping`=1 -> STUCK, `stuck` <= 1.
  - STUCK: `ping`=0 -> LOW; no further events until then.
  - `high_cnt` clears on entry to LOW.
- Event latency: `ping_evt` is high the cycle after `ping` is first sampled high in LOW; exactly 1 cycle wide.
- Epoch counter:
  - `epoch_cnt` updates in the same cycle `ping_evt` asserts; +1 modulo 2^EPOCH_W.
  - Wrap from all-ones to 0 sets `epoch_ovf`.
- Interrupt:
  - Event with `irq_en`=1 -> `irq` <= 1.
  - `irq_ack` with no event -> `irq` <= 0.
  - Event and `irq_ack` in the same cycle -> `irq` stays 1, no overrun.
  - Event with `irq`=1 and no `irq_ack` -> `overrun` <= 1, `irq` stays 1.
  - `irq_en`=0 blocks new irq but does not clear a pending one.
- `clr` vs event in the same cycle:
  - Flags cleared first, then the event applied: `epoch_cnt`=1; `irq`/`overrun` evaluated with `irq` treated as 0.
  - `stuck`/`epoch_ovf` cleared unless re-triggered that cycle.
- No combinational input-to-output paths.

Optional Feature:
- Macro: PING_MON_TIMEOUT_EN.
- Defined:
  - `to_cnt` increments every cycle outside DISARM.
  - It clears on event, `clr` or `rst`.
  - At `to_cnt` == TIMEOUT-1 it saturates and `timeout` <= 1 (sticky until `clr`).
- Undefined: no `to_cnt` register; `timeout` tied 0; TO_W and TIMEOUT unused.

Decomposition:
- Shared package holds:
  - FSM state encodings (2-bit: DISARM=0, LOW=1, HIGH=2, STUCK=3)
  - default parameter constants
- One sub-module, `ping_edge_fsm`:
  - contains the FSM and `high_cnt`
  - outputs `evt` and `stuck_set`
- Top level holds the epoch counter, irq/overrun logic, sticky flags and the optional timeout.

Test Plan (EPOCH_W=4, STUCK_MAX=4, TIMEOUT=20, macro defined):
- Reset release with `ping`=1 for 3 cycles, then 0, then a 1-cycle pulse -> no event for the initial high; one `ping_evt` 1 cycle after the pulse; `epoch_cnt`=1.
- 16 one-cycle pings spaced 3 cycles apart -> `epoch_cnt` wraps 15 -> 0; `epoch_ovf`=1; 16 `ping_evt` pulses.
- `irq_en`=1, two pings without ack -> `irq`=1, `overrun`=1. Then `irq_ack` -> `irq`=0. Ack coincident with an event -> `irq` stays 1, `overrun` unchanged.
- `ping` held high 6 cycles -> one event; `stuck`=1 after 4 high cycles; `ping` low then pulse -> new event counted.
- No ping for 20 cycles after LOW -> `timeout`=1 at cycle 20. `clr` together with an event -> `timeout`/`stuck`/`overrun` = 0, `epoch_cnt`=1, `irq`=1.
- Assert `rst` while in HIGH with `irq` pending -> all outputs 0 next cycle; FSM returns to DISARM.

Source files
------------

// File: rtl/ping_monitor_pkg.sv
// ping_monitor_pkg: shared FSM state encoding and default parameter constants for ping_monitor
package ping_monitor_pkg;

    typedef enum logic [1:0] {
        DISARM = 2'd0,
        LOW    = 2'd1,
        HIGH   = 2'd2,
        STUCK  = 2'd3
    } state_e;

    localparam int          DEF_EPOCH_W   = 16;
    localparam int          DEF_STUCK_MAX = 4;
    localparam int          DEF_TO_W      = 33;
    localparam logic [32:0] DEF_TIMEOUT   = 33'h1_0000_0010;

endpackage

// File: rtl/ping_edge_fsm.sv
// ping_edge_fsm: turns rising ping levels into event strobes and detects ping held high too long
module ping_edge_fsm
    import ping_monitor_pkg::*;
#(
    parameter int STUCK_MAX = DEF_STUCK_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ping,
    output logic       evt,
    output logic       stuck_set,
    output logic [1:0] state
);

    localparam int              HC_W    = $clog2(STUCK_MAX);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(STUCK_MAX - 1);

    state_e          state_q, state_d;
    logic [HC_W-1:0] high_cnt_q, high_cnt_d;

    assign state = state_q;

    // next state, high-level run length, and the combinational event/stuck strobes
    always_comb begin
        state_d    = state_q;
        high_cnt_d = high_cnt_q;
        evt        = 1'b0;
        stuck_set  = 1'b0;
        unique case (state_q)
            DISARM: if (!ping) state_d = LOW;
            LOW: if (ping) begin
                state_d = HIGH;
                evt     = 1'b1;
            end
            HIGH: if (!ping) state_d = LOW;
                else if (high_cnt_q == HC_LAST) begin
                    state_d   = STUCK;
                    stuck_set = 1'b1;
                end else high_cnt_d = high_cnt_q + HC_W'(1);
            STUCK: if (!ping) state_d = LOW;
            default: state_d = DISARM;
        endcase
        if (state_d == LOW) high_cnt_d = '0;
    end

    // state register; reset parks in DISARM so a level already high is never counted
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DISARM;
            high_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            high_cnt_q <= high_cnt_d;
        end
    end

endmodule

// File: rtl/ping_monitor.sv
// ping_monitor: counts ping events, raises an acked irq, flags overrun/stuck/timeout (timeout under PING_MON_TIMEOUT_EN)
module ping_monitor
    import ping_monitor_pkg::*;
#(
    parameter int              EPOCH_W   = DEF_EPOCH_W,
    parameter int              STUCK_MAX = DEF_STUCK_MAX,
    parameter int              TO_W      = DEF_TO_W,
    parameter logic [TO_W-1:0] TIMEOUT   = TO_W'(DEF_TIMEOUT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ping,
    input  logic               irq_en,
    input  logic               irq_ack,
    input  logic               clr,
    output logic               ping_evt,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               epoch_ovf,
    output logic               irq,
    output logic               overrun,
    output logic               stuck,
    output logic               timeout
);

    logic               evt, stuck_set;
    logic [1:0]         state;
    logic               irq_cur;
    logic [EPOCH_W-1:0] epoch_base;
    logic               ping_evt_q, ping_evt_d;
    logic [EPOCH_W-1:0] epoch_cnt_q, epoch_cnt_d;
    logic               epoch_ovf_q, epoch_ovf_d;
    logic               irq_q, irq_d;
    logic               overrun_q, overrun_d;
    logic               stuck_q, stuck_d;

    ping_edge_fsm #(.STUCK_MAX(STUCK_MAX)) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .ping      (ping),
        .evt       (evt),
        .stuck_set (stuck_set),
        .state     (state)
    );

    // clr wipes the flags first, then the same-cycle event is applied on top
    always_comb begin
        irq_cur     = clr ? 1'b0 : irq_q;
        epoch_base  = clr ? '0 : epoch_cnt_q;
        ping_evt_d  = evt;
        epoch_cnt_d = epoch_base + EPOCH_W'(evt);
        epoch_ovf_d = (~clr & epoch_ovf_q) | (evt & (&epoch_base));
        irq_d       = evt ? (irq_en | (irq_cur & ~irq_ack)) : (irq_cur & ~irq_ack);
        overrun_d   = (~clr & overrun_q) | (evt & irq_cur & ~irq_ack);
        stuck_d     = (~clr & stuck_q) | stuck_set;
    end

    // registered outputs so no input reaches an output combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            ping_evt_q  <= 1'b0;
            epoch_cnt_q <= '0;
            epoch_ovf_q <= 1'b0;
            irq_q       <= 1'b0;
            overrun_q   <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            ping_evt_q  <= ping_evt_d;
            epoch_cnt_q <= epoch_cnt_d;
            epoch_ovf_q <= epoch_ovf_d;
            irq_q       <= irq_d;
            overrun_q   <= overrun_d;
            stuck_q     <= stuck_d;
        end
    end

    assign ping_evt  = ping_evt_q;
    assign epoch_cnt = epoch_cnt_q;
    assign epoch_ovf = epoch_ovf_q;
    assign irq       = irq_q;
    assign overrun   = overrun_q;
    assign stuck     = stuck_q;

`ifdef PING_MON_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
    logic            armed, to_hit;

    // cycles since the last event while armed; saturates at TIMEOUT-1
    always_comb begin
        armed     = state != DISARM;
        to_hit    = armed && (to_cnt_q == TIMEOUT - TO_W'(1));
        to_cnt_d  = (clr | evt) ? '0 : (!armed || to_hit) ? to_cnt_q : to_cnt_q + TO_W'(1);
        timeout_d = (~clr & timeout_q) | (to_hit & ~clr & ~evt);
    end

    // timeout counter and sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_to;

    assign unused_to = ^{TIMEOUT, state};
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ping_monitor.sv
// tb_ping_monitor: directed checks of ping_monitor with EPOCH_W=4, STUCK_MAX=4, TIMEOUT=20
module tb_ping_monitor;

`ifdef PING_MON_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1, ping = 1'b0, irq_en = 1'b0, irq_ack = 1'b0, clr = 1'b0;
    logic       ping_evt, epoch_ovf, irq, overrun, stuck, timeout;
    logic [3:0] epoch_cnt;
    int         nvec = 0;
    int         nerr = 0;

    ping_monitor #(.EPOCH_W(4), .STUCK_MAX(4), .TO_W(33), .TIMEOUT(33'd20)) dut (
        .clk       (clk),
        .rst       (rst),
        .ping      (ping),
        .irq_en    (irq_en),
        .irq_ack   (irq_ack),
        .clr       (clr),
        .ping_evt  (ping_evt),
        .epoch_cnt (epoch_cnt),
        .epoch_ovf (epoch_ovf),
        .irq       (irq),
        .overrun   (overrun),
        .stuck     (stuck),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ping = 1'b1;
        tick(); tick();
        nvec++; if ({ping_evt, epoch_cnt, epoch_ovf, irq, overrun, stuck, timeout} !== 10'd0) begin nerr++; $display("FAIL reset_outputs got=%b exp=0", {ping_evt, epoch_cnt, epoch_ovf, irq, overrun, stuck, timeout}); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++; if (ping_evt !== 1'b0 || epoch_cnt !== 4'd0) begin nerr++; $display("FAIL reset_high_no_evt i=%0d evt=%b cnt=%0d exp 0/0", i, ping_evt, epoch_cnt); end
        end
        ping = 1'b0; tick();
        ping = 1'b1; tick();
        nvec++; if (ping_evt !== 1'b1 || epoch_cnt !== 4'd1) begin nerr++; $display("FAIL first_evt evt=%b cnt=%0d exp 1/1", ping_evt, epoch_cnt); end
        ping = 1'b0; tick();
        nvec++; if (ping_evt !== 1'b0 || epoch_cnt !== 4'd1) begin nerr++; $display("FAIL evt_width evt=%b cnt=%0d exp 0/1", ping_evt, epoch_cnt); end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        nvec++; if (epoch_cnt !== 4'd0 || epoch_ovf !== 1'b0) begin nerr++; $display("FAIL clr_epoch cnt=%0d ovf=%b exp 0/0", epoch_cnt, epoch_ovf); end
        for (int i = 0; i < 16; i++) begin
            ping = 1'b1; tick();
            if (ping_evt === 1'b1) pulses++;
            nvec++; if (epoch_cnt !== 4'((i + 1) % 16) || epoch_ovf !== (i == 15)) begin nerr++; $display("FAIL wrap_step i=%0d cnt=%0d ovf=%b exp %0d/%0d", i, epoch_cnt, epoch_ovf, (i + 1) % 16, i == 15); end
            ping = 1'b0; tick();
            nvec++; if (ping_evt !== 1'b0) begin nerr++; $display("FAIL wrap_gap i=%0d evt=%b exp 0", i, ping_evt); end
            tick();
        end
        nvec++; if (pulses != 16) begin nerr++; $display("FAIL wrap_pulses got=%0d exp 16", pulses); end
        nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL wrap_no_irq got=%b exp 0", irq); end
    endtask

    task automatic test_irq();
        clr = 1'b1; tick(); clr = 1'b0;
        irq_en = 1'b1;
        ping = 1'b1; tick(); ping = 1'b0; tick();
        nvec++; if (irq !== 1'b1 || overrun !== 1'b0) begin nerr++; $display("FAIL irq_first irq=%b ovr=%b exp 1/0", irq, overrun); end
        ping = 1'b1; tick(); ping = 1'b0; tick();
        nvec++; if (irq !== 1'b1 || overrun !== 1'b1) begin nerr++; $display("FAIL irq_overrun irq=%b ovr=%b exp 1/1", irq, overrun); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        nvec++; if (irq !== 1'b0 || overrun !== 1'b1) begin nerr++; $display("FAIL irq_ack irq=%b ovr=%b exp 0/1", irq, overrun); end
        clr = 1'b1; tick(); clr = 1'b0;
        ping = 1'b1; tick(); ping = 1'b0; tick();
        nvec++; if (irq !== 1'b1 || overrun !== 1'b0) begin nerr++; $display("FAIL irq_rearm irq=%b ovr=%b exp 1/0", irq, overrun); end
        ping = 1'b1; irq_ack = 1'b1; tick();
        nvec++; if (ping_evt !== 1'b1 || irq !== 1'b1 || overrun !== 1'b0) begin nerr++; $display("FAIL ack_with_evt evt=%b irq=%b ovr=%b exp 1/1/0", ping_evt, irq, overrun); end
        ping = 1'b0; irq_ack = 1'b0; tick();
        irq_en = 1'b0; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        ping = 1'b1; tick(); ping = 1'b0;
        nvec++; if (ping_evt !== 1'b1 || irq !== 1'b0 || overrun !== 1'b0) begin nerr++; $display("FAIL irq_en_blocks evt=%b irq=%b ovr=%b exp 1/0/0", ping_evt, irq, overrun); end
        tick();
    endtask

    task automatic test_stuck();
        clr = 1'b1; tick(); clr = 1'b0;
        ping = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            nvec++; if (ping_evt !== (i == 1) || stuck !== (i >= 5)) begin nerr++; $display("FAIL stuck_hold i=%0d evt=%b stuck=%b exp %0d/%0d", i, ping_evt, stuck, i == 1, i >= 5); end
        end
        nvec++; if (epoch_cnt !== 4'd1) begin nerr++; $display("FAIL stuck_one_evt cnt=%0d exp 1", epoch_cnt); end
        ping = 1'b0; tick();
        ping = 1'b1; tick();
        nvec++; if (ping_evt !== 1'b1 || epoch_cnt !== 4'd2 || stuck !== 1'b1) begin nerr++; $display("FAIL stuck_recover evt=%b cnt=%0d stuck=%b exp 1/2/1", ping_evt, epoch_cnt, stuck); end
        ping = 1'b0; tick();
    endtask

    task automatic test_timeout_clr();
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL timeout_early got=%b exp 0", timeout); end
        tick();
        nvec++; if (timeout !== TO_EN) begin nerr++; $display("FAIL timeout_set got=%b exp %b", timeout, TO_EN); end
        irq_en = 1'b1; ping = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ping = 1'b0; tick();
        ping = 1'b1; tick(); ping = 1'b0; tick();
        nvec++; if ({stuck, overrun, irq, timeout} !== {3'b111, TO_EN} || epoch_cnt !== 4'd2) begin nerr++; $display("FAIL pre_clr s/o/i/t=%b cnt=%0d exp 111%b/2", {stuck, overrun, irq, timeout}, epoch_cnt, TO_EN); end
        clr = 1'b1; ping = 1'b1; tick(); clr = 1'b0;
        nvec++; if ({ping_evt, stuck, overrun, irq, timeout} !== 5'b10010 || epoch_cnt !== 4'd1) begin nerr++; $display("FAIL clr_with_evt e/s/o/i/t=%b cnt=%0d exp 10010/1", {ping_evt, stuck, overrun, irq, timeout}, epoch_cnt); end
    endtask

    task automatic test_reset_mid();
        tick();
        nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL mid_irq_pending got=%b exp 1", irq); end
        rst = 1'b1; tick(); rst = 1'b0;
        nvec++; if ({ping_evt, epoch_cnt, epoch_ovf, irq, overrun, stuck, timeout} !== 10'd0) begin nerr++; $display("FAIL mid_reset got=%b exp 0", {ping_evt, epoch_cnt, epoch_ovf, irq, overrun, stuck, timeout}); end
        tick();
        nvec++; if (ping_evt !== 1'b0 || epoch_cnt !== 4'd0) begin nerr++; $display("FAIL mid_disarm evt=%b cnt=%0d exp 0/0", ping_evt, epoch_cnt); end
        ping = 1'b0; tick();
        ping = 1'b1; tick(); ping = 1'b0;
        nvec++; if (ping_evt !== 1'b1 || epoch_cnt !== 4'd1 || irq !== 1'b1) begin nerr++; $display("FAIL mid_rearm evt=%b cnt=%0d irq=%b exp 1/1/1", ping_evt, epoch_cnt, irq); end
        tick();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_irq();
        test_stuck();
        test_timeout_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
